// File: rtl/hmem_responder.sv
// Word-addressed backing memory that serves one request at a time after a fixed latency.
// Operation encoding of req_operation: 0 LOAD, 1 STORE, 2 CLFLUSH, 3 unknown.
module hmem_responder #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [1:0]       req_operation,
  input  logic [XLEN-1:0]  req_address,
  input  logic [XLEN-1:0]  req_store_word,
  output logic             req_fulfilled,
  output logic [XLEN-1:0]  req_loaded_word,
  output logic             err_sticky,
  output logic [CNT_W-1:0] load_count,
  output logic [CNT_W-1:0] store_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [1:0] MO_LOAD  = 2'd0;
  localparam logic [1:0] MO_STORE = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             ok_q, ok_d;
  logic             ful_q, ful_d;
  logic [XLEN-1:0]  word_q, word_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] lc_q, lc_d;
  logic [CNT_W-1:0] sc_q, sc_d;
  logic             enter_resp_s;
  logic             addr_ok_s;

  logic [XLEN-1:0]  mem [DEPTH];

  // Legal addresses are word aligned and fall inside the backing RAM.
  assign addr_ok_s = (req_address[XLEN-1:AW+2] == {(XLEN-AW-2){1'b0}}) &&
                     (req_address[1:0] == 2'b00);

  // Next-state, capture, statistics and registered response data.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    idx_d        = idx_q;
    data_d       = data_q;
    ok_d         = ok_q;
    err_d        = err_q;
    lc_d         = lc_q;
    sc_d         = sc_q;
    enter_resp_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d   = req_operation;
          idx_d  = req_address[AW+1:2];
          data_d = req_store_word;
          ok_d   = addr_ok_s;
          cnt_d  = LW'(LATENCY);
          if (LATENCY == 0) begin
            state_d      = ST_RESPOND;
            enter_resp_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - LW'(1);
        if (!req_valid) begin
          state_d = ST_IDLE;
        end else if (cnt_q == LW'(1)) begin
          state_d      = ST_RESPOND;
          enter_resp_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
        // Out-of-range LOAD/STORE still count as fulfilled beats.
        if (op_q == MO_LOAD) begin
          if (lc_q != {CNT_W{1'b1}}) lc_d = lc_q + CNT_W'(1);
          else                       lc_d = lc_q;
        end else if (op_q == MO_STORE) begin
          if (sc_q != {CNT_W{1'b1}}) sc_d = sc_q + CNT_W'(1);
          else                       sc_d = sc_q;
        end else begin
          lc_d = lc_q;
        end
        if (!(((op_q == MO_LOAD) || (op_q == MO_STORE)) && ok_q)) err_d = 1'b1;
        else                                                    err_d = err_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ful_d = enter_resp_s;
    if (enter_resp_s && (op_d == MO_LOAD) && ok_d) word_d = mem[idx_d];
    else                                           word_d = {XLEN{1'b0}};
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {LW{1'b0}};
      op_q    <= 2'b00;
      idx_q   <= {AW{1'b0}};
      data_q  <= {XLEN{1'b0}};
      ok_q    <= 1'b0;
      ful_q   <= 1'b0;
      word_q  <= {XLEN{1'b0}};
      err_q   <= 1'b0;
      lc_q    <= {CNT_W{1'b0}};
      sc_q    <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ok_q    <= ok_d;
      ful_q   <= ful_d;
      word_q  <= word_d;
      err_q   <= err_d;
      lc_q    <= lc_d;
      sc_q    <= sc_d;
    end
  end

  // Backing RAM keeps its contents across reset; stores commit at the end of the pulse cycle.
  always_ff @(posedge clk) begin
    if ((state_q == ST_RESPOND) && (op_q == MO_STORE) && ok_q) begin
      mem[idx_q] <= data_q;
    end
  end

  assign req_fulfilled   = ful_q;
  assign req_loaded_word = word_q;
  assign err_sticky      = err_q;
  assign load_count      = lc_q;
  assign store_count     = sc_q;

  hmem_responder_chk u_chk (
    .clk           (clk),
    .reset_n       (reset_n),
    .state         (state_q),
    .fulfilled     (ful_q),
    .req_valid     (req_valid),
    .req_operation (req_operation)
  );

endmodule

// Protocol and state checks for hmem_responder.
module hmem_responder_chk (
  input logic       clk,
  input logic       reset_n,
  input logic [1:0] state,
  input logic       fulfilled,
  input logic       req_valid,
  input logic [1:0] req_operation
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;

  a_no_pulse_idle: assert property (@(posedge clk) disable iff (!reset_n)
    (state == S_IDLE) |-> !fulfilled) else $error("req_fulfilled high in ST_IDLE");

  a_state_known: assert property (@(posedge clk) disable iff (!reset_n)
    !$isunknown(state)) else $error("state is X");

  a_op_stable: assert property (@(posedge clk) disable iff (!reset_n)
    ((state == S_WAIT) && req_valid) |-> $stable(req_operation))
    else $error("req_operation changed while waiting");

endmodule

// File: tb/tb_hmem_responder.sv
// Directed bench for hmem_responder: LATENCY=2 and LATENCY=0 instances checked every cycle
// against a timing/memory model, plus hand-computed expectations per scenario.
module tb_hmem_responder;

  localparam int DEPTH = 1024;
  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_STORE = 2'd1;
  localparam logic [1:0] OP_CLF   = 2'd2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        v    [2];
  logic [1:0]  op   [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic        ful  [2];
  logic [31:0] lw   [2];
  logic        err  [2];
  logic [15:0] lc   [2];
  logic [15:0] sc   [2];

  int tests = 0;
  int fails = 0;
  int lat_cfg [2] = '{2, 0};

  always #5 clk = ~clk;

  hmem_responder #(.XLEN(32), .DEPTH(DEPTH), .LATENCY(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(v[0]), .req_operation(op[0]),
    .req_address(addr[0]), .req_store_word(wdat[0]), .req_fulfilled(ful[0]),
    .req_loaded_word(lw[0]), .err_sticky(err[0]), .load_count(lc[0]), .store_count(sc[0]));

  hmem_responder #(.XLEN(32), .DEPTH(DEPTH), .LATENCY(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(v[1]), .req_operation(op[1]),
    .req_address(addr[1]), .req_store_word(wdat[1]), .req_fulfilled(ful[1]),
    .req_loaded_word(lw[1]), .err_sticky(err[1]), .load_count(lc[1]), .store_count(sc[1]));

  function automatic bit in_range(input logic [31:0] a);
    return (a < 32'(4 * DEPTH)) && (a[1:0] == 2'b00);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a request seen idle at edge c is answered in the cycle after edge c+1+LATENCY,
  // dropped if req_valid is low on any edge before that.
  longint      cyc = 0;
  bit          pend   [2];
  longint      due    [2];
  logic [1:0]  m_op   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_data [2];
  bit          e_ful  [2];
  logic [31:0] e_word [2];
  bit          e_err  [2];
  int          e_lc   [2];
  int          e_sc   [2];
  logic [31:0] mem_m  [2][DEPTH];

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; due[i] = 0; e_ful[i] = 0; e_word[i] = 0;
      e_err[i] = 0; e_lc[i] = 0; e_sc[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!reset_n) begin
          pend[i] = 0; e_ful[i] = 0; e_word[i] = 0; e_err[i] = 0; e_lc[i] = 0; e_sc[i] = 0;
        end else begin
          e_ful[i]  = 0;
          e_word[i] = 0;
          if (pend[i]) begin
            if (cyc == due[i]) begin
              pend[i] = 0;
              if (m_op[i] == OP_STORE) begin
                if (in_range(m_addr[i])) mem_m[i][m_addr[i][$clog2(DEPTH)+1:2]] = m_data[i];
                if (e_sc[i] < 65535) e_sc[i]++;
              end
              if (m_op[i] == OP_LOAD && e_lc[i] < 65535) e_lc[i]++;
              if (!((m_op[i] == OP_LOAD || m_op[i] == OP_STORE) && in_range(m_addr[i])))
                e_err[i] = 1;
            end else if (!v[i]) begin
              pend[i] = 0;
            end
          end else if (v[i]) begin
            pend[i]   = 1;
            due[i]    = cyc + 1 + longint'(lat_cfg[i]);
            m_op[i]   = op[i];
            m_addr[i] = addr[i];
            m_data[i] = wdat[i];
          end
          if (pend[i] && due[i] == cyc + 1) begin
            e_ful[i] = 1;
            if (m_op[i] == OP_LOAD && in_range(m_addr[i]))
              e_word[i] = mem_m[i][m_addr[i][$clog2(DEPTH)+1:2]];
          end
        end
        chk($sformatf("model_ful[%0d]", i),  32'(ful[i]), 32'(e_ful[i]));
        chk($sformatf("model_word[%0d]", i), lw[i], e_word[i]);
        chk($sformatf("model_err[%0d]", i),  32'(err[i]), 32'(e_err[i]));
        chk($sformatf("model_lc[%0d]", i),   32'(lc[i]), 32'(e_lc[i]));
        chk($sformatf("model_sc[%0d]", i),   32'(sc[i]), 32'(e_sc[i]));
      end
    end
  end

  // Raise a request, wait (bounded) for its pulse; unless held, drop valid and let it retire.
  task automatic do_req(input int i, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] d, input bit hold,
                        output logic [31:0] word, output int lat);
    bit found = 0;
    @(negedge clk);
    v[i] = 1'b1; op[i] = o; addr[i] = a; wdat[i] = d;
    lat = 0;
    word = 32'hFFFF_FFFF;
    while (!found && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (ful[i]) begin
        found = 1;
        word = lw[i];
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL timeout[%0d]: no pulse for addr 0x%0h within 20 cycles", i, a);
    end
    if (!hold) begin
      @(negedge clk);
      v[i] = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] w;
  int          lat;
  int          s0, l0, np;

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; op[i] = OP_LOAD; addr[i] = 32'h0; wdat[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ful", 32'(ful[0]), 32'd0);
    chk("rst_lc", 32'(lc[0]), 32'd0);
    reset_n = 1'b1;

    // Single store then load at 0x40.
    do_req(0, OP_STORE, 32'h40, 32'hDEADBEEF, 0, w, lat);
    chk("st_lat", 32'(lat), 32'd3);
    chk("st_cnt", 32'(sc[0]), 32'd1);
    do_req(0, OP_LOAD, 32'h40, 32'h0, 0, w, lat);
    chk("ld_data", w, 32'hDEADBEEF);
    chk("ld_lat", 32'(lat), 32'd3);
    chk("ld_cnt", 32'(lc[0]), 32'd1);

    // Held-valid burst: 8 stores then 8 loads at 0x100..0x11C.
    for (int k = 0; k < 8; k++) begin
      do_req(0, OP_STORE, 32'h100 + 32'(4 * k), 32'(k), 1, w, lat);
      chk($sformatf("burst_st_lat%0d", k), 32'(lat), (k == 0) ? 32'd3 : 32'd4);
    end
    for (int k = 0; k < 8; k++) begin
      do_req(0, OP_LOAD, 32'h100 + 32'(4 * k), 32'h0, (k != 7), w, lat);
      chk($sformatf("burst_ld_data%0d", k), w, 32'(k));
      chk($sformatf("burst_ld_lat%0d", k), 32'(lat), 32'd4);
    end
    chk("burst_sc", 32'(sc[0]), 32'd9);
    chk("burst_lc", 32'(lc[0]), 32'd9);

    // Zero-latency instance.
    do_req(1, OP_STORE, 32'h8, 32'hCAFEF00D, 0, w, lat);
    chk("l0_st_lat", 32'(lat), 32'd1);
    do_req(1, OP_LOAD, 32'h8, 32'h0, 0, w, lat);
    chk("l0_ld_lat", 32'(lat), 32'd1);
    chk("l0_ld_data", w, 32'hCAFEF00D);

    // Abort a store one cycle into the wait.
    do_req(0, OP_STORE, 32'h20, 32'h11, 0, w, lat);
    s0 = int'(sc[0]);
    @(negedge clk);
    v[0] = 1'b1; op[0] = OP_STORE; addr[0] = 32'h20; wdat[0] = 32'h99;
    @(negedge clk);
    v[0] = 1'b0;
    np = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ful[0]) np++;
    end
    chk("abort_pulses", 32'(np), 32'd0);
    chk("abort_sc", 32'(sc[0]), 32'(s0));
    do_req(0, OP_LOAD, 32'h20, 32'h0, 0, w, lat);
    chk("abort_data", w, 32'h11);

    // CLFLUSH then out-of-range load.
    chk("err_clear", 32'(err[0]), 32'd0);
    s0 = int'(sc[0]);
    l0 = int'(lc[0]);
    do_req(0, OP_CLF, 32'h30, 32'h0, 0, w, lat);
    chk("clf_word", w, 32'h0);
    chk("clf_err", 32'(err[0]), 32'd1);
    chk("clf_lc", 32'(lc[0]), 32'(l0));
    chk("clf_sc", 32'(sc[0]), 32'(s0));
    do_req(0, OP_LOAD, 32'(4 * DEPTH), 32'h0, 0, w, lat);
    chk("oor_word", w, 32'h0);
    chk("oor_lc", 32'(lc[0]), 32'(l0 + 1));
    chk("oor_sc", 32'(sc[0]), 32'(s0));

    // Asynchronous reset in the middle of a wait.
    @(negedge clk);
    v[0] = 1'b1; op[0] = OP_STORE; addr[0] = 32'h60; wdat[0] = 32'h77;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_ful", 32'(ful[0]), 32'd0);
    chk("arst_word", lw[0], 32'h0);
    chk("arst_err", 32'(err[0]), 32'd0);
    chk("arst_lc", 32'(lc[0]), 32'd0);
    chk("arst_sc", 32'(sc[0]), 32'd0);
    @(negedge clk);
    v[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    do_req(0, OP_LOAD, 32'h40, 32'h0, 0, w, lat);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_data", w, 32'hDEADBEEF);
    do_req(1, OP_LOAD, 32'h8, 32'h0, 0, w, lat);
    chk("post_rst_l0_data", w, 32'hCAFEF00D);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
